// File: rtl/simon_sequencer_if.sv
// simon_sequencer_if: game-side bundle between the sequencer, the LFSR and the IO wrapper.
//   rand_i  [3:0]        LFSR nibble; only [1:0] selects the colour.
//   start_i              start/restart request, level-sampled.
//   btn_i   [3:0]        player buttons, one cycle per press.
//   led_o   [3:0]        one-hot colour during playback.
//   level_o [LVL_W-1:0]  current sequence length.
//   busy_o / win_o / lose_o  status flags.
// Modport slave is the sequencer; master is whatever drives it (wrapper or bench).
interface simon_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [3:0]       rand_i;
    logic             start_i;
    logic [3:0]       btn_i;
    logic [3:0]       led_o;
    logic [LVL_W-1:0] level_o;
    logic             busy_o;
    logic             win_o;
    logic             lose_o;

    modport slave (
        input  rand_i, start_i, btn_i,
        output led_o, level_o, busy_o, win_o, lose_o
    );

    modport master (
        output rand_i, start_i, btn_i,
        input  led_o, level_o, busy_o, win_o, lose_o
    );
endinterface

// File: rtl/simon_sequencer.sv
// simon_sequencer: builds a growing colour sequence from LFSR nibbles, plays it on
// four LEDs, then checks the player's button presses against it.
//   clk_i  clock; rst_i synchronous active-high reset.
//   bus    simon_sequencer_if.slave (rand_i, start_i, btn_i in; led_o, level_o,
//          busy_o, win_o, lose_o out).
// Optional: define SIMON_TIMEOUT_EN to lose after TIMEOUT_CYCLES idle cycles in INPUT.
// The bus interface must be instantiated with the same DEPTH as this module.
module simon_sequencer #(
    parameter int DEPTH          = 16,
    parameter int ON_CYCLES      = 8,
    parameter int OFF_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    simon_sequencer_if.slave  bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LVL_W  = IDX_W + 1;
    localparam int T_MAX0 = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int T_MAX  = (T_MAX0 > TIMEOUT_CYCLES) ? T_MAX0 : TIMEOUT_CYCLES;
    localparam int T_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE, APPEND, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE
    } state_t;

    state_t           state;
    logic [LVL_W-1:0] len;
    logic [IDX_W-1:0] idx;
    logic [T_W-1:0]   timer;
    logic [3:0]       led_q;
    logic             busy_q;
    logic             win_q;
    logic             lose_q;

    logic [1:0]       mem [DEPTH];

    logic [3:0]       exp_onehot;
    logic             last_step;
    logic             seq_full;
    logic [1:0]       unused_rand_hi;

    assign exp_onehot     = 4'b0001 << mem[idx];
    assign last_step      = ({1'b0, idx} == (len - LVL_W'(1)));
    assign seq_full       = (len == LVL_W'(DEPTH));
    assign unused_rand_hi = bus.rand_i[3:2];

    // Sequence storage is never reset; only [0, len) is ever read.
    always_ff @(posedge clk_i) begin
        if (state == APPEND)
            mem[len[IDX_W-1:0]] <= bus.rand_i[1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            len    <= '0;
            idx    <= '0;
            timer  <= '0;
            led_q  <= 4'b0;
            busy_q <= 1'b0;
            win_q  <= 1'b0;
            lose_q <= 1'b0;
        end else begin
            // LED is a registered read of the step being shown, so it trails
            // the SHOW_ON window by one cycle but keeps its full length.
            led_q <= (state == SHOW_ON) ? exp_onehot : 4'b0;

            case (state)
                IDLE, WIN, LOSE: begin
                    if (bus.start_i) begin
                        len    <= '0;
                        state  <= APPEND;
                        busy_q <= 1'b1;
                        win_q  <= 1'b0;
                        lose_q <= 1'b0;
                    end
                end

                APPEND: begin
                    len   <= len + LVL_W'(1);
                    idx   <= '0;
                    timer <= '0;
                    state <= SHOW_ON;
                end

                SHOW_ON: begin
                    if (timer == T_W'(ON_CYCLES - 1)) begin
                        timer <= '0;
                        state <= SHOW_OFF;
                    end else begin
                        timer <= timer + T_W'(1);
                    end
                end

                SHOW_OFF: begin
                    if (timer == T_W'(OFF_CYCLES - 1)) begin
                        timer <= '0;  // also the idle-count start for INPUT
                        if (last_step) begin
                            idx    <= '0;
                            state  <= INPUT;
                            busy_q <= 1'b0;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= SHOW_ON;
                        end
                    end else begin
                        timer <= timer + T_W'(1);
                    end
                end

                INPUT: begin
                    if (bus.btn_i != 4'b0) begin
`ifdef SIMON_TIMEOUT_EN
                        timer <= '0;
`endif
                        // Exact match against a one-hot value also rejects
                        // multi-button presses.
                        if (bus.btn_i == exp_onehot) begin
                            if (!last_step) begin
                                idx <= idx + IDX_W'(1);
                            end else if (seq_full) begin
                                state <= WIN;
                                win_q <= 1'b1;
                            end else begin
                                state  <= APPEND;
                                busy_q <= 1'b1;
                            end
                        end else begin
                            state  <= LOSE;
                            lose_q <= 1'b1;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (timer == T_W'(TIMEOUT_CYCLES - 1)) begin
                        state  <= LOSE;
                        lose_q <= 1'b1;
                    end else begin
                        timer <= timer + T_W'(1);
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led_o   = led_q;
    assign bus.level_o = len;
    assign bus.busy_o  = busy_q;
    assign bus.win_o   = win_q;
    assign bus.lose_o  = lose_q;
endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer with DEPTH=4, ON=8, OFF=4, TIMEOUT=64.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_simon_sequencer;
    localparam int DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    simon_sequencer_if #(.DEPTH(DEPTH)) bus ();

    simon_sequencer #(
        .DEPTH(DEPTH), .ON_CYCLES(8), .OFF_CYCLES(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] rnd;
        logic [3:0] btn;
        int         n;
        logic [3:0] led;
        logic [2:0] lvl;
        logic       busy;
        logic       win;
        logic       lose;
    } vec_t;

    vec_t tbl [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [1:0] cols [4];

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] rnd,
                                input logic [3:0] b, input int n, input logic [3:0] led,
                                input logic [2:0] lvl, input logic bz, input logic w,
                                input logic l);
        vec_t v;
        v.rst = r; v.start = s; v.rnd = rnd; v.btn = b; v.n = n;
        v.led = led; v.lvl = lvl; v.busy = bz; v.win = w; v.lose = l;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_outs(input string name, input logic [3:0] led, input logic [2:0] lvl,
                              input logic bz, input logic w, input logic l);
        n_checks++;
        if ({bus.led_o, bus.level_o, bus.busy_o, bus.win_o, bus.lose_o} !== {led, lvl, bz, w, l}) begin
            n_fail++;
            $display("FAIL %s: led=%b level=%0d busy=%b win=%b lose=%b, required led=%b level=%0d busy=%b win=%b lose=%b",
                     name, bus.led_o, bus.level_o, bus.busy_o, bus.win_o, bus.lose_o, led, lvl, bz, w, l);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    // Holds illegal presses and a start request throughout playback; both must be
    // ignored. Returns once busy_o drops (entry to INPUT), bounded.
    task automatic wait_input(input string name);
        bit done = 0;
        bus.btn_i   = 4'b1111;
        bus.start_i = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (!bus.busy_o) done = 1;
        end
        bus.btn_i   = 4'b0;
        bus.start_i = 1'b0;
        check_bit({name, ".reached_input"}, done, 1'b1);
        check_bit({name, ".no_lose"}, bus.lose_o, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rand_i = 4'b0; bus.start_i = 1'b0; bus.btn_i = 4'b0;

        //                rst start rand     btn      n  led      lvl bsy win lose
        tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 2, 4'b0000, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 2, 4'b0000, 0, 0, 0, 0)); // stays IDLE
        tbl.push_back(mk(0, 1, 4'b1010, 4'b0000, 1, 4'b0000, 0, 1, 0, 0)); // APPEND
        tbl.push_back(mk(0, 0, 4'b1010, 4'b0000, 1, 4'b0000, 1, 1, 0, 0)); // SHOW_ON, led lag
        tbl.push_back(mk(0, 1, 4'b1010, 4'b0001, 8, 4'b0100, 1, 1, 0, 0)); // lit; start/btn ignored
        tbl.push_back(mk(0, 0, 4'b1010, 4'b0000, 3, 4'b0000, 1, 1, 0, 0)); // dark
        tbl.push_back(mk(0, 0, 4'b1010, 4'b0000, 1, 4'b0000, 1, 0, 0, 0)); // INPUT
        tbl.push_back(mk(0, 0, 4'b1010, 4'b0000, 3, 4'b0000, 1, 0, 0, 0)); // waits
        tbl.push_back(mk(0, 0, 4'b0111, 4'b0100, 1, 4'b0000, 1, 1, 0, 0)); // correct -> APPEND
        tbl.push_back(mk(0, 0, 4'b0111, 4'b0000, 1, 4'b0000, 2, 1, 0, 0)); // len 2
        tbl.push_back(mk(0, 0, 4'b0111, 4'b0000, 8, 4'b0100, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0111, 4'b0000, 4, 4'b0000, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0111, 4'b0000, 8, 4'b1000, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0111, 4'b0000, 3, 4'b0000, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0111, 4'b0000, 1, 4'b0000, 2, 0, 0, 0)); // INPUT
        tbl.push_back(mk(0, 0, 4'b0111, 4'b0100, 1, 4'b0000, 2, 0, 0, 0)); // step 0 ok
        tbl.push_back(mk(0, 0, 4'b0111, 4'b0001, 1, 4'b0000, 2, 0, 0, 1)); // wrong colour
        tbl.push_back(mk(0, 0, 4'b0111, 4'b1000, 2, 4'b0000, 2, 0, 0, 1)); // LOSE holds
        tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 1, 4'b0000, 0, 1, 0, 0)); // restart
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 1, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 8, 4'b0010, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 3, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 1, 4'b0000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0110, 1, 4'b0000, 1, 0, 0, 1)); // multi-press

        for (int i = 0; i < tbl.size(); i++) begin
            rst_i       = tbl[i].rst;
            bus.start_i = tbl[i].start;
            bus.rand_i  = tbl[i].rnd;
            bus.btn_i   = tbl[i].btn;
            for (int c = 0; c < tbl[i].n; c++) begin
                tick();
                check_outs($sformatf("vec%0d.%0d", i, c), tbl[i].led, tbl[i].lvl,
                           tbl[i].busy, tbl[i].win, tbl[i].lose);
            end
        end
        bus.start_i = 1'b0; bus.btn_i = 4'b0;

        // Full game to DEPTH from LOSE; upper rand bits set to prove they are ignored.
        cols[0] = 2'd2; cols[1] = 2'd1; cols[2] = 2'd3; cols[3] = 2'd0;
        bus.rand_i  = {2'b11, cols[0]};
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check_outs("win.start", 4'b0000, 0, 1, 0, 0);
        for (int r = 0; r < DEPTH; r++) begin
            wait_input($sformatf("win.r%0d", r));
            check_bit($sformatf("win.r%0d.level", r), bus.level_o == 3'(r + 1), 1'b1);
            for (int k = 0; k <= r; k++) begin
                if (k == r && r < DEPTH - 1) bus.rand_i = {2'b01, cols[r + 1]};
                bus.btn_i = 4'b0001 << cols[k];
                tick();
                bus.btn_i = 4'b0;
            end
        end
        check_outs("win.final", 4'b0000, 4, 0, 1, 0);
        bus.btn_i = 4'b0010;
        tick();
        bus.btn_i = 4'b0;
        check_outs("win.hold", 4'b0000, 4, 0, 1, 0);

        // Reset in the middle of playback.
        bus.rand_i  = 4'b0011;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check_outs("rst.start", 4'b0000, 0, 1, 0, 0);
        begin
            bit lit = 0;
            for (int c = 0; c < 20 && !lit; c++) begin
                tick();
                if (bus.led_o != 4'b0) lit = 1;
            end
            check_bit("rst.led_lit", lit, 1'b1);
            check_outs("rst.lit_value", 4'b1000, 1, 1, 0, 0);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_outs("rst.mid_show", 4'b0000, 0, 0, 0, 0);
        tick();
        check_outs("rst.idle", 4'b0000, 0, 0, 0, 0);

`ifdef SIMON_TIMEOUT_EN
        bus.rand_i  = 4'b0001;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        wait_input("tmo.r0");
        bus.rand_i = 4'b0010;
        bus.btn_i  = 4'b0010;
        tick();
        bus.btn_i  = 4'b0;
        wait_input("tmo.r1");
        for (int c = 0; c < 63; c++) tick();
        check_bit("tmo.63_idle", bus.lose_o, 1'b0);
        bus.btn_i = 4'b0010;           // press on the 64th cycle restarts the count
        tick();
        bus.btn_i = 4'b0;
        check_bit("tmo.press", bus.lose_o, 1'b0);
        for (int c = 0; c < 63; c++) tick();
        check_bit("tmo.63_again", bus.lose_o, 1'b0);
        tick();
        check_bit("tmo.expire", bus.lose_o, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
- Game-sequencer stage directly downstream of the 4-bit LFSR; consumes its `random_value` nibble as the source of new sequence steps.
- Builds a growing colour sequence of up to DEPTH steps in internal storage, plays it out on four LEDs, then checks player button presses against it.
- Reports win/lose status and current level to the top-level IO wrapper.

Parameters:
- DEPTH, 16: maximum sequence length; power of two, 2..64.
- ON_CYCLES, 8: cycles each step's LED is lit during playback; >=1.
- OFF_CYCLES, 4: dark gap cycles after each lit step; >=1.
- TIMEOUT_CYCLES, 64: input idle limit; used only when SIMON_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- rand_i  in  4  LFSR nibble; only bits [1:0] used as colour index.
- start_i  in  1  start/restart request, level-sampled.
- btn_i  in  4  player buttons, one cycle per press (debounced/edge-detected upstream).
- led_o  out  4  one-hot colour during playback, else 0.
- level_o  out  $clog2(DEPTH)+1  current sequence length.
- busy_o  out  1  high in APPEND, SHOW_ON, SHOW_OFF.
- win_o  out  1  high while in WIN.
- lose_o  out  1  high while in LOSE.

Behaviour:
- States: IDLE, APPEND, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE. All outputs are Moore, decoded from registered state, len, idx and mem.
- Reset (rst_i high at a clk_i edge):
  - state = IDLE, len = 0, idx = 0, timer = 0.
  - Outputs: led_o = 0, level_o = 0, busy_o = 0, win_o = 0, lose_o = 0.
  - Reset overrides everything, including mid-playback and mid-input.
  - mem contents need not be cleared.
- start_i is honoured only in IDLE, WIN and LOSE: len <= 0, state <= APPEND. In all other states it is ignored.
- APPEND (exactly 1 cycle):
  - mem[len] <= rand_i[1:0]; len <= len+1; idx <= 0; timer <= 0; go SHOW_ON.
- SHOW_ON:
  - led_o = 1 << mem[idx].
  - Lasts exactly ON_CYCLES cycles, then go SHOW_OFF with timer reset.
- SHOW_OFF:
  - led_o = 0; lasts exactly OFF_CYCLES cycles.
  - At the end: if idx == len-1, go INPUT with idx <= 0; else idx <= idx+1 and go SHOW_ON.
- Playback timing: led_o first goes nonzero 2 cycles after the edge that samples start_i.
- INPUT:
  - led_o = 0; each btn_i cycle is evaluated independently.
  - btn_i == 0: no action.
  - btn_i one-hot and equal to 1 << mem[idx]: correct.
    - If idx < len-1: idx <= idx+1.
    - Else if len == DEPTH: go WIN.
    - Else: go APPEND.
  - btn_i not one-hot (2+ bits) or wrong colour: go LOSE.
- btn_i is ignored in every state except INPUT.
- WIN / LOSE: win_o / lose_o held high until start_i or reset; level_o holds the final len.
- level_o = len. Width $clog2(DEPTH)+1 so DEPTH itself is representable; len never exceeds DEPTH.
- Timers count 0..N-1 and use the minimal width for max(ON_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES).

Optional Feature:
- Macro: SIMON_TIMEOUT_EN.
- Defined:
  - In INPUT, a timer counts cycles with btn_i == 0; any nonzero btn_i clears it.
  - Reaching TIMEOUT_CYCLES consecutive idle cycles goes to LOSE on that edge.
  - The timer clears on entry to INPUT.
- Undefined: INPUT waits indefinitely; the timeout counter logic is absent.

Test Plan:
- Reset then idle: hold rst_i 2 cycles, then release.
  - Required: led_o = 0, level_o = 0, win_o = lose_o = busy_o = 0; state stays IDLE with no start_i.
- First round: rand_i = 4'b1010, pulse start_i.
  - Required: level_o = 1; led_o = 4'b0100 for exactly 8 cycles starting 2 cycles after the start edge; then 4 dark cycles; then INPUT with busy_o = 0.
- Correct input grows sequence: in INPUT press btn_i = 4'b0100; set rand_i = 4'b0111.
  - Required: APPEND, level_o = 2; playback 4'b0100 then 4'b1000, each 8 on / 4 off.
- Wrong and multi-press: in INPUT press 4'b0001 where 4'b0100 is expected.
  - Required: lose_o = 1 next cycle. Separately, btn_i = 4'b0110 must also give lose_o = 1.
  - Then start_i: lose_o = 0, level_o = 1.
- Win at DEPTH: with DEPTH = 4, answer all rounds correctly.
  - Required: win_o = 1, level_o = 4; btn_i presses during playback ignored; start_i during SHOW_ON ignored.
  - Also: rst_i mid-SHOW_ON returns led_o = 0, level_o = 0 next cycle.
- With SIMON_TIMEOUT_EN, TIMEOUT_CYCLES = 64: no press for 64 cycles in INPUT gives lose_o = 1; a press at cycle 63 restarts the count.
